// File: rtl/shift_counter_pkg.sv
// Shared constants and types for the ping-pong one-hot shift counter.
package shift_counter_pkg;

  // Default number of bits in the one-hot position register
  localparam int unsigned SHIFT_COUNTER_WIDTH = 8;

  // One-hot value loaded on reset and on recovery from an illegal state
  localparam int unsigned SHIFT_COUNTER_RESET_VAL = 1;

  // LEFT walks the token toward the MSB, RIGHT toward the LSB
  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } shift_dir_t;

endpackage

// File: rtl/shift_counter.sv
// Free-running one-hot ping-pong shift counter: the token walks LSB->MSB, bounces,
// walks back MSB->LSB and repeats with period 2*(WIDTH-1). Output is a plain register.
// Optional build macro SHIFT_COUNTER_ENABLE_EN adds an active-high advance enable `en`.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SHIFT_COUNTER_ENABLE_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] count
);

  if (WIDTH < 2) begin : gen_width_check
    $error("shift_counter: WIDTH must be at least 2");
  end

  localparam logic [WIDTH-1:0] ResetCount = WIDTH'(SHIFT_COUNTER_RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  shift_dir_t       dir_q, dir_d;
  logic             onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
  assign onehot = (count_q != '0) && ((count_q & (count_q - 1'b1)) == '0);

  // Next-state: walk, bounce at either end without dwell, recover from corruption
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (!onehot) begin
      count_d = ResetCount;
      dir_d   = DIR_LEFT;
    end else if (dir_q == DIR_LEFT) begin
      if (count_q[WIDTH-1]) begin
        count_d = count_q >> 1;
        dir_d   = DIR_RIGHT;
      end else begin
        count_d = count_q << 1;
      end
    end else begin
      if (count_q[0]) begin
        count_d = count_q << 1;
        dir_d   = DIR_LEFT;
      end else begin
        count_d = count_q >> 1;
      end
    end
`ifdef SHIFT_COUNTER_ENABLE_EN
    // A stalled counter holds everything, including a corrupted value
    if (!en) begin
      count_d = count_q;
      dir_d   = dir_q;
    end
`endif
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ResetCount;
      dir_q   <= DIR_LEFT;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_shift_counter.sv
// Scoreboard bench for shift_counter (WIDTH=8): stimulus pushes the expected count for
// each upcoming sample; a monitor pops and compares on every falling edge, or at once
// when the stimulus fires chk_now for asynchronous checks.
module tb_shift_counter;

  logic       clk;
  logic       reset;
  logic [7:0] count;
`ifdef SHIFT_COUNTER_ENABLE_EN
  logic       en;
`endif

  int unsigned checks;
  int unsigned errors;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq[20];
  event        chk_now;

  shift_counter #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
`ifdef SHIFT_COUNTER_ENABLE_EN
    .en   (en),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: compare against the oldest expectation whenever a sample point arrives
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk or chk_now);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (count !== exp_v) begin
          errors++;
          $display("FAIL count @%0t: got %h expected %h", $time, count, exp_v);
        end
      end
    end
  end

  // Expect value v after the next rising edge (sampled on the following falling edge)
  task automatic exp_next(input logic [7:0] v);
    @(posedge clk);
    #1 exp_q.push_back(v);
  endtask

  // Immediate (between-edge) expectation
  task automatic exp_now(input logic [7:0] v);
    exp_q.push_back(v);
    ->chk_now;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog @%0t: simulation did not complete", $time);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
            8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    reset = 1'b0;
`ifdef SHIFT_COUNTER_ENABLE_EN
    en = 1'b1;
`endif

    // Power-up reset held across ten rising edges
    for (int i = 0; i < 10; i++) exp_next(8'h01);
    @(negedge clk);
    #5 reset = 1'b1;

    // Twenty clocks of the ping-pong walk, including both end bounces
    for (int i = 0; i < 20; i++) exp_next(seq[i]);

    // Advance to 0x20 on the way down, then reset mid-cycle
    exp_next(8'h80);
    exp_next(8'h40);
    exp_next(8'h20);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 exp_now(8'h01);
    for (int i = 0; i < 10; i++) exp_next(8'h01);
    @(negedge clk);
    #3 reset = 1'b1;
    exp_next(8'h02);
    exp_next(8'h04);

    // Corrupt the register to all-zero: recovery to 0x01 then normal walk
    @(negedge clk);
    #3 force dut.count_q = 8'h00;
    #1 exp_now(8'h00);
    #1 release dut.count_q;
    exp_next(8'h01);
    exp_next(8'h02);

    // Corrupt to two bits set
    @(negedge clk);
    #3 force dut.count_q = 8'h03;
    #1 exp_now(8'h03);
    #1 release dut.count_q;
    exp_next(8'h01);
    exp_next(8'h02);
    exp_next(8'h04);
    exp_next(8'h08);

`ifdef SHIFT_COUNTER_ENABLE_EN
    // Stall at 0x08 for five edges, resume, then reset while stalled
    @(negedge clk);
    #3 en = 1'b0;
    for (int i = 0; i < 5; i++) exp_next(8'h08);
    @(negedge clk);
    #3 en = 1'b1;
    exp_next(8'h10);
    @(negedge clk);
    #3 en = 1'b0;
    reset = 1'b0;
    #1 exp_now(8'h01);
    exp_next(8'h01);
    exp_next(8'h01);
    @(negedge clk);
    #3 reset = 1'b1;
    en = 1'b1;
    exp_next(8'h02);
`endif

    // Every expectation must have been consumed by the monitor
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_counter.md
Name: shift_counter

Overview:
- Free-running one-hot "ping-pong" shift counter: a single 1 bit walks from LSB to MSB, then back from MSB to LSB, and repeats.
- Drives an 8-bit LED/display bus (`count`) in lab-level designs.
- One clock domain; no handshake.
- Output comes straight from a register, so `count` is glitch-free.

Parameters:
- WIDTH, 8, number of bits in `count`; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- count  output  WIDTH  one-hot position register; bit i high means the token is at position i.

Behaviour:
- State elements:
  - `count` register, WIDTH bits.
  - direction flag `dir`: LEFT moves toward the MSB, RIGHT moves toward the LSB.
- Reset (reset=0, asynchronous, regardless of clk):
  - count = 1 (for WIDTH=8, count = 00000001).
  - dir = LEFT.
  - State holds for as long as reset is low.
- On each rising clk edge with reset=1:
  - dir=LEFT, count[WIDTH-1]=0: count <= count << 1; dir unchanged.
  - dir=LEFT, count[WIDTH-1]=1: count <= count >> 1; dir <= RIGHT (MSB bounce, no dwell).
  - dir=RIGHT, count[0]=0: count <= count >> 1; dir unchanged.
  - dir=RIGHT, count[0]=1: count <= count << 1; dir <= LEFT (LSB bounce, no dwell).
- Sequence for WIDTH=8 from reset, one value per clock:
  - 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,...
  - Period is 2*(WIDTH-1) = 14 clocks.
  - Each end value is held for exactly one cycle per period.
- Latency: first rising edge after reset deasserts gives count=00000010.
- Reset asserted mid-sequence:
  - count returns to 1 and dir to LEFT immediately, without waiting for a clock.
  - Sequence restarts from the beginning on release.
- Robustness: if count is ever not one-hot (zero or multiple bits set, e.g. after an upset), the next edge forces count=1 and dir=LEFT.
- Elaboration-time error if WIDTH<2.

Optional Feature:
- Macro: SHIFT_COUNTER_ENABLE_EN.
- Defined:
  - Adds input port `en` (1 bit, active-high), placed after reset.
  - When en=0 at a rising edge: count and dir hold, and the illegal-state recovery is also suppressed.
  - When en=1: behaviour exactly as above.
  - Reset overrides en.
- Undefined:
  - No `en` port.
  - Counter advances every clock.

Decomposition:
- Package shift_counter_pkg holds:
  - default width constant SHIFT_COUNTER_WIDTH = 8.
  - enum typedef shift_dir_t {DIR_LEFT, DIR_RIGHT}.
  - constant for the reset one-hot value (1).
- Single flat module; no sub-module. Next-state logic is one combinational block plus one sequential block.

Test Plan:
- Power-up with reset=0 for 200 ns (20 ns clock period) -> count=00000001 throughout, including across clock edges.
- Release reset, run 20 clocks -> count follows 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04,08,10,20,40 (hex); exactly one bit set every cycle.
- End-point dwell check -> 80 appears for exactly 1 cycle, followed by 40; 01 appears for exactly 1 cycle, followed by 02.
- Assert reset asynchronously mid-cycle while count=20 (e.g. 3000 ns into the run), hold 200 ns -> count=01 immediately, before the next edge; after release, next edge gives 02.
- Force count to 00000000 or 00000011 via a deposit -> next edge gives count=01, followed by 02.
- With SHIFT_COUNTER_ENABLE_EN:
  - hold en=0 for 5 clocks at count=08 -> count stays 08.
  - set en=1 -> count goes to 10.
  - assert reset with en=0 -> count=01.
